nordic_cross_painter: RTL and testbench

NORDIC_CROSS_PAINTER -- requirements
Module: nordic_cross_painter

---
 rtl/nordic_flag_pkg.sv | 39 +++
 rtl/nordic_cross_painter_cross_region.sv | 28 ++
 rtl/nordic_cross_painter.sv | 157 +++++++++++++++
 tb/tb_nordic_cross_painter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nordic_flag_pkg.sv
// Shared definitions for the Nordic cross painter: flag enum, flag geometry,
// cross bounds and 4-bit-per-channel colours.
package nordic_flag_pkg;

   typedef enum logic [1:0] {
      FLAG_SE = 2'd0,
      FLAG_DK = 2'd1,
      FLAG_FI = 2'd2,
      FLAG_NO = 2'd3
   } flag_t;

   typedef logic [11:0] rgb12_t;

   localparam int FLAG_W = 640;
   localparam int FLAG_H = 400;

   // Band limits are exclusive on both ends
   localparam int SE_Y_LO = 160, SE_Y_HI = 240, SE_X_LO = 200, SE_X_HI = 280;
   localparam int DK_Y_LO = 170, DK_Y_HI = 230, DK_X_LO = 180, DK_X_HI = 240;
   localparam int FI_Y_LO = 150, FI_Y_HI = 250, FI_X_LO = 180, FI_X_HI = 280;
   localparam int NO_OY_LO = 140, NO_OY_HI = 260, NO_OX_LO = 170, NO_OX_HI = 290;
   localparam int NO_CY_LO = 165, NO_CY_HI = 235, NO_CX_LO = 195, NO_CX_HI = 265;

   localparam rgb12_t COL_BLACK  = 12'h000;
   localparam rgb12_t SE_BG      = 12'h06A;
   localparam rgb12_t SE_CROSS   = 12'hFC0;
   localparam rgb12_t DK_BG      = 12'hC12;
   localparam rgb12_t DK_CROSS   = 12'hFFF;
   localparam rgb12_t FI_BG      = 12'hFFF;
   localparam rgb12_t FI_CROSS   = 12'h028;
   localparam rgb12_t NO_BG      = 12'hB12;
   localparam rgb12_t NO_OUTLINE = 12'hFFF;
   localparam rgb12_t NO_CROSS   = 12'h026;

   function automatic logic inBand(input logic [9:0] v, input int lo, input int hi);
      return (int'(v) > lo) && (int'(v) < hi);
   endfunction

endpackage

// File: rtl/nordic_cross_painter_cross_region.sv
// cross_region: combinational test of a flag-local coordinate against the
// cross (and, for Norway, the white outline) of the selected flag.
module cross_region
   import nordic_flag_pkg::*;
(
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   input  flag_t      i_flag,
   output logic       o_inOutline,
   output logic       o_inCross
);

   always_comb begin
      o_inOutline = 1'b0;
      o_inCross   = 1'b0;
      case (i_flag)
         FLAG_SE: o_inCross = inBand(i_y, SE_Y_LO, SE_Y_HI) || inBand(i_x, SE_X_LO, SE_X_HI);
         FLAG_DK: o_inCross = inBand(i_y, DK_Y_LO, DK_Y_HI) || inBand(i_x, DK_X_LO, DK_X_HI);
         FLAG_FI: o_inCross = inBand(i_y, FI_Y_LO, FI_Y_HI) || inBand(i_x, FI_X_LO, FI_X_HI);
         FLAG_NO: begin
            o_inOutline = inBand(i_y, NO_OY_LO, NO_OY_HI) || inBand(i_x, NO_OX_LO, NO_OX_HI);
            o_inCross   = inBand(i_y, NO_CY_LO, NO_CY_HI) || inBand(i_x, NO_CX_LO, NO_CX_HI);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/nordic_cross_painter.sv
// Two-stage pixel pipeline painting a Nordic cross flag at (FLAG_X0, FLAG_Y0).
// Define FLAG_SCROLL_EN to scroll the flag horizontally by one pixel per frame.
module nordic_cross_painter
   import nordic_flag_pkg::*;
#(
   parameter int CORDW   = 10,
   parameter int CHANW   = 4,
   parameter int FLAG_X0 = 0,
   parameter int FLAG_Y0 = 0
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             de,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             frame,
   input  logic [1:0]       flag_sel,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic [CHANW-1:0] vga_r,
   output logic [CHANW-1:0] vga_g,
   output logic [CHANW-1:0] vga_b
);

   flag_t        r_activeFlag;
   flag_t        w_flag;
   int           w_dx;
   int           w_dy;
   logic         w_inFlag;
   logic [9:0]   w_x;
   logic [9:0]   w_y;
   logic [9:0]   w_xs;
   logic         w_inOutline;
   logic         w_inCross;

   logic         r_s1De;
   logic         r_s1InFlag;
   logic         r_s1Hsync;
   logic         r_s1Vsync;
   logic         r_s1Outline;
   logic         r_s1Cross;
   flag_t        r_s1Flag;

   rgb12_t       w_rgb;
   rgb12_t       r_rgb;
   logic         r_hsync;
   logic         r_vsync;

   // The frame pixel itself already uses the newly requested flag
   always_ff @(posedge clk_pix) begin
      if (rst_pix)
         r_activeFlag <= FLAG_SE;
      else if (frame)
         r_activeFlag <= flag_t'(flag_sel);
   end

   assign w_flag   = frame ? flag_t'(flag_sel) : r_activeFlag;
   assign w_dx     = int'(sx) - FLAG_X0;
   assign w_dy     = int'(sy) - FLAG_Y0;
   assign w_inFlag = (w_dx >= 0) && (w_dx < FLAG_W) && (w_dy >= 0) && (w_dy < FLAG_H);
   assign w_x      = w_dx[9:0];
   assign w_y      = w_dy[9:0];

`ifdef FLAG_SCROLL_EN
   logic [9:0]  r_offset;
   logic [9:0]  w_offsetNext;
   logic [9:0]  w_offset;
   logic [10:0] w_sum;

   assign w_offsetNext = (r_offset == 10'(FLAG_W - 1)) ? 10'd0 : r_offset + 10'd1;

   always_ff @(posedge clk_pix) begin
      if (rst_pix)
         r_offset <= 10'd0;
      else if (frame)
         r_offset <= w_offsetNext;
   end

   assign w_offset = frame ? w_offsetNext : r_offset;
   assign w_sum    = {1'b0, w_x} + {1'b0, w_offset};
   assign w_xs     = (w_sum >= 11'(FLAG_W)) ? 10'(w_sum - 11'(FLAG_W)) : w_sum[9:0];
`else
   assign w_xs = w_x;
`endif

   cross_region u_region (
      .i_x         (w_xs),
      .i_y         (w_y),
      .i_flag      (w_flag),
      .o_inOutline (w_inOutline),
      .o_inCross   (w_inCross)
   );

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_s1De      <= 1'b0;
         r_s1InFlag  <= 1'b0;
         r_s1Hsync   <= 1'b1;
         r_s1Vsync   <= 1'b1;
         r_s1Outline <= 1'b0;
         r_s1Cross   <= 1'b0;
         r_s1Flag    <= FLAG_SE;
      end else begin
         r_s1De      <= de;
         r_s1InFlag  <= w_inFlag;
         r_s1Hsync   <= hsync;
         r_s1Vsync   <= vsync;
         r_s1Outline <= w_inOutline;
         r_s1Cross   <= w_inCross;
         r_s1Flag    <= w_flag;
      end
   end

   // Norway's blue cross sits on top of its white outline
   always_comb begin
      w_rgb = COL_BLACK;
      if (r_s1De && r_s1InFlag) begin
         case (r_s1Flag)
            FLAG_SE: w_rgb = r_s1Cross ? SE_CROSS : SE_BG;
            FLAG_DK: w_rgb = r_s1Cross ? DK_CROSS : DK_BG;
            FLAG_FI: w_rgb = r_s1Cross ? FI_CROSS : FI_BG;
            FLAG_NO: w_rgb = r_s1Cross ? NO_CROSS : (r_s1Outline ? NO_OUTLINE : NO_BG);
            default: w_rgb = COL_BLACK;
         endcase
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_rgb   <= COL_BLACK;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else begin
         r_rgb   <= w_rgb;
         r_hsync <= r_s1Hsync;
         r_vsync <= r_s1Vsync;
      end
   end

   assign vga_hsync = r_hsync;
   assign vga_vsync = r_vsync;

   generate
      if (CHANW == 8) begin : g_chan8
         assign vga_r = {r_rgb[11:8], r_rgb[11:8]};
         assign vga_g = {r_rgb[7:4],  r_rgb[7:4]};
         assign vga_b = {r_rgb[3:0],  r_rgb[3:0]};
      end else begin : g_chan4
         assign vga_r = r_rgb[11:8];
         assign vga_g = r_rgb[7:4];
         assign vga_b = r_rgb[3:0];
      end
   endgenerate

endmodule

// File: tb/tb_nordic_cross_painter.sv
// Scoreboard bench for nordic_cross_painter: 4-bit and 8-bit channel instances
// share one input stream; expectations are queued per cycle and checked 2 cycles later.
module tb_nordic_cross_painter;

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_pix = 1'b1;
   logic [9:0] sx = '0;
   logic [9:0] sy = '0;
   logic       de = 1'b0;
   logic       hsync = 1'b1;
   logic       vsync = 1'b1;
   logic       frame = 1'b0;
   logic [1:0] flag_sel = 2'd0;

   logic       hs4, vs4, hs8, vs8;
   logic [3:0] r4, g4, b4;
   logic [7:0] r8, g8, b8;

   exp_t  expQ[$];
   string nameQ[$];
   int    nChecks = 0;
   int    nFail   = 0;
   int    nPushed = 0;
   int    nPopped = 0;

   always #5 clk = ~clk;

   nordic_cross_painter #(.CORDW(10), .CHANW(4)) dut4 (
      .clk_pix(clk), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
      .hsync(hsync), .vsync(vsync), .frame(frame), .flag_sel(flag_sel),
      .vga_hsync(hs4), .vga_vsync(vs4), .vga_r(r4), .vga_g(g4), .vga_b(b4)
   );

   nordic_cross_painter #(.CORDW(10), .CHANW(8)) dut8 (
      .clk_pix(clk), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
      .hsync(hsync), .vsync(vsync), .frame(frame), .flag_sel(flag_sel),
      .vga_hsync(hs8), .vga_vsync(vs8), .vga_r(r8), .vga_g(g8), .vga_b(b8)
   );

   // Drive one pixel per cycle; a reset also turns any still-pending expectation idle
   task automatic applyStimulus(input string name, input logic rst, input logic frm,
                                input logic [1:0] sel, input int x, input int y,
                                input logic d, input logic hs, input logic vs,
                                input logic [11:0] rgb);
      exp_t e;
      @(negedge clk);
      rst_pix  = rst;
      frame    = frm;
      flag_sel = sel;
      sx       = 10'(x);
      sy       = 10'(y);
      de       = d;
      hsync    = hs;
      vsync    = vs;
      if (rst) begin
         foreach (expQ[i]) expQ[i] = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
         e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
      end else begin
         e = '{rgb: rgb, hs: hs, vs: vs};
      end
      expQ.push_back(e);
      nameQ.push_back(name);
      nPushed++;
   endtask

   task automatic checkOutput();
      exp_t        e;
      string       n;
      logic [23:0] exp8;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      nPopped++;
      nChecks++;
      if ({r4, g4, b4} !== e.rgb || hs4 !== e.hs || vs4 !== e.vs) begin
         nFail++;
         $display("[TB] FAIL %s ch4: got rgb=%03h hs=%0b vs=%0b, want rgb=%03h hs=%0b vs=%0b",
                  n, {r4, g4, b4}, hs4, vs4, e.rgb, e.hs, e.vs);
      end
      exp8 = {e.rgb[11:8], e.rgb[11:8], e.rgb[7:4], e.rgb[7:4], e.rgb[3:0], e.rgb[3:0]};
      nChecks++;
      if ({r8, g8, b8} !== exp8 || hs8 !== e.hs || vs8 !== e.vs) begin
         nFail++;
         $display("[TB] FAIL %s ch8: got rgb=%06h hs=%0b vs=%0b, want rgb=%06h hs=%0b vs=%0b",
                  n, {r8, g8, b8}, hs8, vs8, exp8, e.hs, e.vs);
      end
   endtask

   // Monitor: an entry is due once two later clock edges have passed since it was driven
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() >= 2) checkOutput();
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      for (int i = 0; i < 3; i++)
         applyStimulus("reset_idle", 1, 0, 0, 220, 50, 1, 0, 0, 12'h000);

      applyStimulus("se_cross_220_50",    0, 0, 0, 220,  50, 1, 1, 1, 12'hFC0);
      applyStimulus("se_bg_50_50",        0, 0, 0,  50,  50, 1, 1, 1, 12'h06A);
      applyStimulus("se_row_220_200",     0, 0, 0, 220, 200, 1, 1, 1, 12'hFC0);
      applyStimulus("de0_220_200",        0, 0, 0, 220, 200, 0, 1, 1, 12'h000);
      applyStimulus("sy400_220",          0, 0, 0, 220, 400, 1, 1, 1, 12'h000);
      applyStimulus("sx639_50",           0, 0, 0, 639,  50, 1, 1, 1, 12'h06A);
      applyStimulus("sx640_50",           0, 0, 0, 640,  50, 1, 1, 1, 12'h000);
      applyStimulus("se_x200_edge",       0, 0, 0, 200,  50, 1, 1, 1, 12'h06A);
      applyStimulus("se_x201",            0, 0, 0, 201,  50, 1, 1, 1, 12'hFC0);
      applyStimulus("se_y160_edge",       0, 0, 0,  50, 160, 1, 1, 1, 12'h06A);
      applyStimulus("se_y161",            0, 0, 0,  50, 161, 1, 1, 1, 12'hFC0);
      applyStimulus("hsync_pre",          0, 0, 0,  50,  50, 1, 1, 1, 12'h06A);
      applyStimulus("hsync_low",          0, 0, 0,  50,  50, 1, 0, 1, 12'h06A);
      applyStimulus("hsync_post",         0, 0, 0,  50,  50, 1, 1, 1, 12'h06A);
      applyStimulus("vsync_low",          0, 0, 0,  50,  50, 1, 1, 0, 12'h06A);
      applyStimulus("sel3_mid_230_200",   0, 0, 3, 230, 200, 1, 1, 1, 12'hFC0);
      applyStimulus("sel3_mid_175_50",    0, 0, 3, 175,  50, 1, 1, 1, 12'h06A);

      applyStimulus("frame_no",           0, 1, 3,   0,   0, 0, 1, 1, 12'h000);
      applyStimulus("no_cross_230_200",   0, 0, 3, 230, 200, 1, 1, 1, 12'h026);
      applyStimulus("no_outline_175_50",  0, 0, 3, 175,  50, 1, 1, 1, 12'hFFF);
      applyStimulus("no_bg_10_10",        0, 0, 3,  10,  10, 1, 1, 1, 12'hB12);
      applyStimulus("no_edge_290_50",     0, 0, 3, 290,  50, 1, 1, 1, 12'hB12);
      applyStimulus("no_prio_200_150",    0, 0, 3, 200, 150, 1, 1, 1, 12'h026);

      applyStimulus("frame_dk",           0, 1, 1,   0,   0, 0, 1, 1, 12'h000);
      applyStimulus("dk_bg_10_10",        0, 0, 1,  10,  10, 1, 1, 1, 12'hC12);
      applyStimulus("dk_cross_200_50",    0, 0, 1, 200,  50, 1, 1, 1, 12'hFFF);

      applyStimulus("frame_fi",           0, 1, 2,   0,   0, 0, 1, 1, 12'h000);
      applyStimulus("fi_bg_10_10",        0, 0, 2,  10,  10, 1, 1, 1, 12'hFFF);
      applyStimulus("fi_cross_200_50",    0, 0, 2, 200,  50, 1, 1, 1, 12'h028);
      applyStimulus("fi_y249",            0, 0, 2,  10, 249, 1, 1, 1, 12'h028);
      applyStimulus("fi_y250",            0, 0, 2,  10, 250, 1, 1, 1, 12'hFFF);

      applyStimulus("pre_reset_fi",       0, 0, 2, 200,  50, 1, 0, 0, 12'h028);
      applyStimulus("reset_with_frame",   1, 1, 1, 220,  50, 1, 0, 0, 12'h000);
      applyStimulus("post_reset_se",      0, 0, 1,  10,  10, 1, 1, 1, 12'h06A);
      applyStimulus("post_reset_se_x",    0, 0, 1, 220,  50, 1, 1, 1, 12'hFC0);

`ifdef FLAG_SCROLL_EN
      for (int i = 0; i < 640; i++)
         applyStimulus("scroll_frame", 0, 1, 0, 0, 0, 0, 1, 1, 12'h000);
      applyStimulus("scroll_wrap_190_50", 0, 0, 0, 190, 50, 1, 1, 1, 12'h06A);
      for (int i = 0; i < 20; i++)
         applyStimulus("scroll_frame", 0, 1, 0, 0, 0, 0, 1, 1, 12'h000);
      applyStimulus("scroll20_190_50",    0, 0, 0, 190, 50, 1, 1, 1, 12'hFC0);
`else
      for (int i = 0; i < 20; i++)
         applyStimulus("noscroll_frame", 0, 1, 0, 0, 0, 0, 1, 1, 12'h000);
      applyStimulus("noscroll_190_50",    0, 0, 0, 190, 50, 1, 1, 1, 12'h06A);
`endif

      applyStimulus("drain_0",            0, 0, 0,   0,   0, 0, 1, 1, 12'h000);
      applyStimulus("drain_1",            0, 0, 0,   0,   0, 0, 1, 1, 12'h000);
      repeat (3) @(posedge clk);
      #2;

      // Entries still queued here never reached a comparison
      nChecks++;
      if (nPopped + expQ.size() != nPushed || nPopped < nPushed - 1) begin
         nFail++;
         $display("[TB] FAIL entry_count: got %0d checked, want at least %0d of %0d",
                  nPopped, nPushed - 1, nPushed);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
